// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder over a word-organised data RAM.
// Performs RISC-V byte/halfword/word lane steering, load extension and access checks.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        we_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [2:0]  funct3_reg;

  logic        accept, commit, wr_en;
  logic        op_we;
  logic [31:0] op_addr, op_wdata;
  logic [2:0]  op_f3;
  logic        f3_bad, misalign, out_range, err;
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]  lane_en;
  logic [31:0] wdata_lane, rd_word, fmt_data, load_data;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign accept = req_valid && (state_reg == IDLE);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accepting edge, so use the live request.
  assign op_we    = (state_reg == IDLE) ? req_we     : we_reg;
  assign op_addr  = (state_reg == IDLE) ? req_addr   : addr_reg;
  assign op_wdata = (state_reg == IDLE) ? req_wdata  : wdata_reg;
  assign op_f3    = (state_reg == IDLE) ? req_funct3 : funct3_reg;

  assign f3_bad    = (op_f3 == 3'b011) || (op_f3[2:1] == 2'b11) || (op_we && op_f3[2]);
  assign misalign  = ((op_f3[1:0] == 2'b01) && op_addr[0]) ||
                     ((op_f3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
  assign out_range = |op_addr[31:DEPTH_LOG2+2];
  assign err       = f3_bad || misalign || out_range;
  assign idx       = op_addr[DEPTH_LOG2+1:2];
  assign wr_en     = commit && reset && op_we && !err;

  always_comb begin
    lane_en    = 4'b1111;
    wdata_lane = op_wdata;
    case (op_f3[1:0])
      2'b00: begin
        lane_en    = 4'b0001 << op_addr[1:0];
        wdata_lane = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        lane_en    = op_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{op_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] bank [DEPTH];
      always_ff @(posedge clk) begin
        if (wr_en && lane_en[gi]) bank[idx] <= wdata_lane[8*gi +: 8];
      end
      assign rd_word[8*gi +: 8] = bank[idx];
    end
  endgenerate

  assign rd_byte = rd_word[8*op_addr[1:0] +: 8];
  assign rd_half = op_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    fmt_data = rd_word;
    case (op_f3)
      3'b000:  fmt_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  fmt_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  fmt_data = {24'd0, rd_byte};
      3'b101:  fmt_data = {16'd0, rd_half};
      default: fmt_data = rd_word;
    endcase
  end

  assign load_data = (op_we || err) ? 32'd0 : fmt_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      we_reg     <= 1'b0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      funct3_reg <= 3'd0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg     <= req_we;
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
        funct3_reg <= req_funct3;
      end
      if (commit) begin
        rsp_rdata <= load_data;
        rsp_err   <= err;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder against a byte-array reference model.
// A second instance with zero wait states covers the minimum-latency path.
module tb_data_mem_responder;

  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_we;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [2:0]  z_req_funct3;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_err, z_busy;
  logic [31:0] z_rsp_rdata;

  data_mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  data_mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_funct3(z_req_funct3),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .busy(z_busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference memory: 256 bytes, little-endian.
  logic [7:0] mem_m [256];

  task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int size;
    logic [31:0] v;
    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    er = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4) ||
         ((a % size) != 0) || (a >= 32'd256);
    rd = 32'd0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < size; i++) mem_m[a + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v = v | (32'(mem_m[a + i]) << (8 * i));
        if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
        rd = v;
      end
    end
  endtask

  // Entry and exit: 1 time unit after a rising edge, responder idle.
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, input int bp, output logic [31:0] rd);
    int lat;
    logic [31:0] exp_rd;
    logic exp_er, er;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
    for (int k = 0; k < 20 && !req_ready; k++) begin @(posedge clk); #1; end
    if (!req_ready) begin
      check("ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      rd = 32'd0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_funct3 = 3'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("latency", 32'(lat), 32'(W + 1));
    model(we, a, wd, f3, exp_rd, exp_er);
    rd = rsp_rdata;
    er = rsp_err;
    check("rdata", rd, exp_rd);
    check("err", 32'(er), 32'(exp_er));
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, rd);
      check("bp_err", 32'(rsp_err), 32'(er));
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("ready_after_rsp", 32'(req_ready), 32'd1);
    check("valid_after_rsp", 32'(rsp_valid), 32'd0);
  endtask

  logic [31:0] rd;
  logic [31:0] init_w;
  int acc_cyc [4];
  int cyc, n_acc, n_rsp;
  logic accepted;
  logic [31:0] b2b_data [4];
  logic [31:0] exp_rd;
  logic exp_er;
  logic rwe;
  logic [31:0] raddr;

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0;
    z_req_funct3 = '0; z_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Give every RAM word a known value.
    for (int w = 0; w < 64; w++) begin
      init_w = $urandom;
      if (init_w == 32'hDEADBEEF) init_w = 32'h0;
      xact(1'b1, 32'(4 * w), init_w, 3'b010, 0, rd);
    end

    // Reset in the middle of a store's wait states.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    xact(1'b0, 32'h10, 32'h0, 3'b010, 0, rd);

    // Lane steering and extension.
    xact(1'b1, 32'h20, 32'h11223344, 3'b010, 0, rd);
    xact(1'b1, 32'h21, 32'h000000AA, 3'b000, 0, rd);
    xact(1'b0, 32'h20, 32'h0, 3'b010, 0, rd);
    check("lane_lw", rd, 32'h1122AA44);
    xact(1'b0, 32'h21, 32'h0, 3'b000, 0, rd);
    check("lane_lb", rd, 32'hFFFFFFAA);
    xact(1'b0, 32'h21, 32'h0, 3'b100, 0, rd);
    check("lane_lbu", rd, 32'h000000AA);
    xact(1'b0, 32'h22, 32'h0, 3'b101, 0, rd);
    check("lane_lhu", rd, 32'h00001122);

    // Backpressure for 5 cycles.
    xact(1'b0, 32'h20, 32'h0, 3'b001, 5, rd);

    // Error cases, each followed by a load of the affected word.
    xact(1'b0, 32'h05, 32'h0, 3'b001, 0, rd);
    xact(1'b0, 32'h04, 32'h0, 3'b010, 0, rd);
    xact(1'b1, 32'h12, 32'h55AA55AA, 3'b010, 0, rd);
    xact(1'b0, 32'h10, 32'h0, 3'b010, 0, rd);
    xact(1'b0, 32'h100, 32'h0, 3'b010, 1, rd);
    xact(1'b0, 32'h00, 32'h0, 3'b011, 0, rd);
    xact(1'b0, 32'h00, 32'h0, 3'b010, 0, rd);
    xact(1'b1, 32'h08, 32'h12345678, 3'b100, 0, rd);
    xact(1'b0, 32'h08, 32'h0, 3'b010, 0, rd);

    // Back-to-back alternating sw/lw to 0x30 with req_valid held high.
    b2b_data[0] = $urandom; b2b_data[2] = $urandom;
    cyc = 0; n_acc = 0; n_rsp = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = b2b_data[0];
    req_funct3 = 3'b010;
    while ((n_acc < 4 || n_rsp < 4) && cyc < 80) begin
      accepted = req_valid && req_ready;
      if (accepted) begin acc_cyc[n_acc] = cyc; n_acc++; end
      if (rsp_valid) begin
        model(n_rsp % 2 == 0, 32'h30, b2b_data[n_rsp], 3'b010, exp_rd, exp_er);
        check("b2b_rdata", rsp_rdata, exp_rd);
        check("b2b_err", 32'(rsp_err), 32'(exp_er));
        if (n_rsp % 2 == 1) check("b2b_lw_data", rsp_rdata, b2b_data[n_rsp - 1]);
        n_rsp++;
      end
      @(posedge clk); #1;
      cyc++;
      if (accepted) begin
        if (n_acc < 4) begin
          req_we = (n_acc % 2 == 0); req_wdata = b2b_data[n_acc];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd4);
    check("b2b_responses", 32'(n_rsp), 32'd4);
    for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(W + 2));

    // Random traffic.
    for (int t = 0; t < 300; t++) begin
      rwe = 1'($urandom);
      raddr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 259));
      if ($urandom_range(0, 1) == 1) raddr = raddr & ~32'd3;
      xact(rwe, raddr, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 2), rd);
    end

    // Zero-wait-state instance: latency 1 and no turnaround while responding.
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h40;
    z_req_wdata = 32'hCAFEF00D; z_req_funct3 = 3'b010;
    check("z_ready_idle", 32'(z_req_ready), 32'd1);
    @(posedge clk); #1;
    check("z_lat_valid", 32'(z_rsp_valid), 32'd1);
    check("z_st_err", 32'(z_rsp_err), 32'd0);
    check("z_st_rdata", z_rsp_rdata, 32'd0);
    z_req_we = 1'b0; z_req_wdata = 32'h0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("z_ready_resp", 32'(z_req_ready), 32'd0);
    end
    z_rsp_ready = 1'b1;
    @(posedge clk); #1;
    z_rsp_ready = 1'b0;
    check("z_ready_after", 32'(z_req_ready), 32'd1);
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    check("z_ld_valid", 32'(z_rsp_valid), 32'd1);
    check("z_ld_rdata", z_rsp_rdata, 32'hCAFEF00D);
    z_rsp_ready = 1'b1;
    @(posedge clk); #1;
    z_rsp_ready = 1'b0;
    check("z_busy_end", 32'(z_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's load/store port; it owns a word-organised data RAM and services one request at a time.
- Requests arrive over a valid/ready request channel; results leave over a valid/ready response channel after a configurable number of wait states.
- It performs RISC-V byte, halfword and word lane steering, plus sign/zero extension of load data.
- It flags misaligned, out-of-range and illegal-size accesses.

Parameters:
- DEPTH_LOG2, 6: log2 of RAM depth in 32-bit words. Default gives 64 words = 256 bytes.
- WAIT_CYCLES, 2: number of wait-state cycles between request acceptance and commit. Range 0..15.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  a request is present on the request channel.
- req_ready  output  1  the responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned: sb uses [7:0], sh uses [15:0].
- req_funct3  input  3  RISC-V access size/sign field: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- rsp_valid  output  1  a response is present on the response channel.
- rsp_ready  input  1  the requester accepts the response.
- rsp_rdata  output  32  formatted load data; 0 for stores and for errors.
- rsp_err  output  1  the access was rejected.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0.
  - RAM contents are not reset.
- Reset mid-operation aborts the transaction. A store is not committed unless its commit edge occurred before reset asserted.

State machine (IDLE, WAIT, RESP):
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch we/addr/wdata/funct3.
  - Next state is WAIT with counter=WAIT_CYCLES-1, or RESP directly if WAIT_CYCLES=0.
- WAIT:
  - req_ready=0.
  - The counter decrements each cycle; at 0 the next state is RESP.
- Commit edge (the edge that enters RESP):
  - Error check is evaluated.
  - A store without error writes the RAM.
  - A load reads the RAM, formats the data, and registers it into rsp_rdata.
  - rsp_err is registered on the same edge.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid&rsp_ready.
  - On handshake: next state IDLE, rsp_valid=0.
  - rsp_rdata and rsp_err hold their last values; they are don't-care while rsp_valid=0.
  - req_ready=0 in RESP; there is no same-cycle turnaround.

Latency and throughput:
- Accept-to-rsp_valid = WAIT_CYCLES+1 cycles.
- Minimum issue interval = WAIT_CYCLES+2 cycles.

Error conditions (any one sets rsp_err=1, suppresses the write, and forces rsp_rdata=0):
- funct3 in {011,110,111}.
- A store with funct3[2]=1.
- Halfword access with addr[0]=1.
- Word access with addr[1:0]!=0.
- addr >= 4*2^DEPTH_LOG2; all upper address bits are checked, with no aliasing.

Lane rules:
- Word index is addr[DEPTH_LOG2+1:2].
- sb writes byte lane addr[1:0] only.
- sh writes lanes {addr[1],0} and {addr[1],1}.
- sw writes all four lanes.
- lb/lh: selected lane(s) sign-extended to 32 bits.
- lbu/lhu: zero-extended.
- lw: whole word.

Other rules:
- req_* inputs are ignored outside IDLE; the requester holds them stable only until the accepting edge.
- rsp_ready asserted while rsp_valid=0 has no effect.

Test Plan:
- Reset: hold reset=0 mid-WAIT of a sw to 0x10 data 0xDEADBEEF, release; then lw 0x10 → rsp_err=0, rsp_rdata ≠ 0xDEADBEEF (write aborted); req_ready=1 in the first cycle after release.
- Lanes: sw 0x20←0x11223344; sb 0x21←0x000000AA; lw 0x20 → 0x1122AA44; lb 0x21 → 0xFFFFFFAA; lbu 0x21 → 0x000000AA; lhu 0x22 → 0x00001122.
- Latency: with WAIT_CYCLES=2, rsp_valid rises exactly 3 cycles after acceptance. With WAIT_CYCLES=0 it rises 1 cycle after acceptance, and req_ready stays 0 until the response handshake.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_rdata and rsp_err stable, req_ready=0, busy=1; raise rsp_ready → the next cycle is IDLE with req_ready=1.
- Errors, each returning rsp_err=1 and rsp_rdata=0 with RAM unchanged (confirmed by a following lw):
  - lh at 0x05.
  - sw at 0x12.
  - lw at 0x100 (DEPTH_LOG2=6).
  - funct3=011.
  - store with funct3=100.
- Back-to-back: assert req_valid continuously for 4 alternating sw/lw to 0x30 → exactly 4 acceptances spaced WAIT_CYCLES+2 cycles apart; each lw returns the preceding sw's data.
